lut_corr_apply: RTL and testbench



---
 rtl/lut_corr_apply_pkg.sv | 25 ++
 rtl/lut_corr_apply_chan.sv | 66 ++++++
 rtl/lut_corr_apply.sv | 155 +++++++++++++++
 tb/tb_lut_corr_apply.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_corr_apply_pkg.sv
// Shared defaults, FSM encoding and saturation helpers for the LUT correction
// apply stage.
package lut_corr_apply_pkg;

  localparam int RAW_W_DEF = 13;
  localparam int LUT_W_DEF = 21;
  localparam int FRAC_DEF  = 7;
  localparam int LAT_DEF   = 2;
  localparam int N_CH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/lut_corr_apply_chan.sv
// One channel: round the LUT word to integer LSBs, subtract it from the aligned
// raw sample, clamp to the raw range and register the result with its sat flag.
module corr_sat_chan
  import lut_corr_apply_pkg::*;
#(
  parameter int RAW_W = RAW_W_DEF,
  parameter int LUT_W = LUT_W_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_i,
  input  logic                    corr_en_i,
  input  logic signed [RAW_W-1:0] raw_i,
  input  logic signed [LUT_W-1:0] lut_i,
  output logic signed [RAW_W-1:0] corr_o,
  output logic                    sat_o
);

  localparam logic signed [LUT_W:0]   ROUND = (LUT_W+1)'(1 << (FRAC - 1));
  localparam logic signed [LUT_W+1:0] MAX_W = (LUT_W+2)'(sat_max(RAW_W));
  localparam logic signed [LUT_W+1:0] MIN_W = (LUT_W+2)'(sat_min(RAW_W));
  localparam logic signed [RAW_W-1:0] MAX_R = RAW_W'(sat_max(RAW_W));
  localparam logic signed [RAW_W-1:0] MIN_R = RAW_W'(sat_min(RAW_W));

  logic signed [LUT_W:0]   lut_ext;
  logic signed [LUT_W:0]   corr_lsb;
  logic signed [LUT_W+1:0] raw_ext;
  logic signed [LUT_W+1:0] diff;
  logic signed [RAW_W-1:0] corr_d, corr_q;
  logic                    sat_d, sat_q;

  // One guard bit keeps lut + half-LSB from wrapping before the shift.
  assign lut_ext  = {lut_i[LUT_W-1], lut_i};
  assign corr_lsb = (lut_ext + ROUND) >>> FRAC;
  assign raw_ext  = {{(LUT_W+2-RAW_W){raw_i[RAW_W-1]}}, raw_i};
  assign diff     = raw_ext - {corr_lsb[LUT_W], corr_lsb};

  always_comb begin
    corr_d = diff[RAW_W-1:0];
    sat_d  = 1'b0;
    if (!corr_en_i) begin
      corr_d = raw_i;
    end else if (diff > MAX_W) begin
      corr_d = MAX_R;
      sat_d  = 1'b1;
    end else if (diff < MIN_W) begin
      corr_d = MIN_R;
      sat_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_q <= '0;
      sat_q  <= 1'b0;
    end else if (en_i) begin
      corr_q <= corr_d;
      sat_q  <= sat_d;
    end
  end

  assign corr_o = corr_q;
  assign sat_o  = sat_q;

endmodule

// File: rtl/lut_corr_apply.sv
// Aligns raw BPM I/Q with the LUT read latency, applies the correction per
// channel inside a triggered window and reports per-window saturation.
//   state  | meaning
//   IDLE   | waiting for the delayed trig
//   ACTIVE | emitting window samples, accumulating sat flags
//   DONE   | one-cycle win_done, latch sat_status
module lut_corr_apply
  import lut_corr_apply_pkg::*;
#(
  parameter int RAW_W = RAW_W_DEF,
  parameter int LUT_W = LUT_W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int LAT   = LAT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trig,
  input  logic [7:0]              win_len,
  input  logic                    corr_en,
  input  logic signed [RAW_W-1:0] bpm1_i_raw,
  input  logic signed [RAW_W-1:0] bpm1_q_raw,
  input  logic signed [RAW_W-1:0] bpm2_i_raw,
  input  logic signed [RAW_W-1:0] bpm2_q_raw,
  input  logic signed [LUT_W-1:0] bpm1_i_lut_out,
  input  logic signed [LUT_W-1:0] bpm1_q_lut_out,
  input  logic signed [LUT_W-1:0] bpm2_i_lut_out,
  input  logic signed [LUT_W-1:0] bpm2_q_lut_out,
  output logic signed [RAW_W-1:0] bpm1_i_corr,
  output logic signed [RAW_W-1:0] bpm1_q_corr,
  output logic signed [RAW_W-1:0] bpm2_i_corr,
  output logic signed [RAW_W-1:0] bpm2_q_corr,
  output logic                    corr_valid,
  output logic                    win_done,
  output logic [3:0]              sat_status,
  output logic                    overrun
);

  logic signed [RAW_W-1:0] raw_in   [N_CH];
  logic signed [LUT_W-1:0] lut_in   [N_CH];
  logic signed [RAW_W-1:0] corr_out [N_CH];
  logic signed [RAW_W-1:0] raw_dly_q [N_CH][LAT];
  logic [LAT-1:0]          trig_dly_q;
  logic                    trig_al;
  logic [N_CH-1:0]         sat_vec;
  logic                    chan_en;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] acc_q, acc_d;
  logic [3:0] sat_status_q, sat_status_d;
  logic       overrun_q, overrun_d;

  assign raw_in[0] = bpm1_i_raw;
  assign raw_in[1] = bpm1_q_raw;
  assign raw_in[2] = bpm2_i_raw;
  assign raw_in[3] = bpm2_q_raw;
  assign lut_in[0] = bpm1_i_lut_out;
  assign lut_in[1] = bpm1_q_lut_out;
  assign lut_in[2] = bpm2_i_lut_out;
  assign lut_in[3] = bpm2_q_lut_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_dly_q <= '0;
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < LAT; s++)
          raw_dly_q[c][s] <= '0;
    end else begin
      trig_dly_q <= {trig_dly_q[LAT-2:0], trig};
      for (int c = 0; c < N_CH; c++) begin
        raw_dly_q[c][0] <= raw_in[c];
        for (int s = 1; s < LAT; s++)
          raw_dly_q[c][s] <= raw_dly_q[c][s-1];
      end
    end
  end

  assign trig_al = trig_dly_q[LAT-1];

  // Channel registers load only for samples that belong to the window, so the
  // outputs hold their last value everywhere else.
  assign chan_en = (state_d == ST_ACTIVE);

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    corr_sat_chan #(
      .RAW_W(RAW_W),
      .LUT_W(LUT_W),
      .FRAC (FRAC)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en_i     (chan_en),
      .corr_en_i(corr_en),
      .raw_i    (raw_dly_q[g][LAT-1]),
      .lut_i    (lut_in[g]),
      .corr_o   (corr_out[g]),
      .sat_o    (sat_vec[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    sat_status_d = sat_status_q;
    overrun_d    = overrun_q;
    unique case (state_q)
      ST_IDLE: begin
        if (trig_al) begin
          cnt_d   = win_len;
          acc_d   = '0;
          state_d = (win_len == 8'd0) ? ST_DONE : ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        acc_d = acc_q | sat_vec;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) state_d = ST_DONE;
        if (trig_al) overrun_d = 1'b1;
      end
      ST_DONE: begin
        sat_status_d = acc_q;
        state_d      = ST_IDLE;
        if (trig_al) overrun_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      sat_status_q <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      sat_status_q <= sat_status_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bpm1_i_corr = corr_out[0];
  assign bpm1_q_corr = corr_out[1];
  assign bpm2_i_corr = corr_out[2];
  assign bpm2_q_corr = corr_out[3];
  assign corr_valid  = (state_q == ST_ACTIVE);
  assign win_done    = (state_q == ST_DONE);
  assign sat_status  = sat_status_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_lut_corr_apply.sv
// Bench for lut_corr_apply: window-level reference model checked every cycle,
// plus directed vectors with literal expectations.
module tb_lut_corr_apply;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic corr_en = 1'b1;
  logic [7:0] win_len = 8'd0;
  int raw_s[4];
  int lut_s[4];

  logic signed [12:0] bpm1_i_raw, bpm1_q_raw, bpm2_i_raw, bpm2_q_raw;
  logic signed [20:0] lut_p1[4];
  logic signed [20:0] lut_p2[4];
  logic signed [12:0] bpm1_i_corr, bpm1_q_corr, bpm2_i_corr, bpm2_q_corr;
  logic corr_valid, win_done, overrun;
  logic [3:0] sat_status;

  int chk_cnt = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  assign bpm1_i_raw = 13'(raw_s[0]);
  assign bpm1_q_raw = 13'(raw_s[1]);
  assign bpm2_i_raw = 13'(raw_s[2]);
  assign bpm2_q_raw = 13'(raw_s[3]);

  // Stand-in for the LUT stage: the word for a sample arrives two cycles later.
  always @(posedge clk) begin
    for (int c = 0; c < 4; c++) begin
      lut_p1[c] <= 21'(lut_s[c]);
      lut_p2[c] <= lut_p1[c];
    end
  end

  lut_corr_apply dut (
    .clk(clk), .rst(rst), .trig(trig), .win_len(win_len), .corr_en(corr_en),
    .bpm1_i_raw(bpm1_i_raw), .bpm1_q_raw(bpm1_q_raw),
    .bpm2_i_raw(bpm2_i_raw), .bpm2_q_raw(bpm2_q_raw),
    .bpm1_i_lut_out(lut_p2[0]), .bpm1_q_lut_out(lut_p2[1]),
    .bpm2_i_lut_out(lut_p2[2]), .bpm2_q_lut_out(lut_p2[3]),
    .bpm1_i_corr(bpm1_i_corr), .bpm1_q_corr(bpm1_q_corr),
    .bpm2_i_corr(bpm2_i_corr), .bpm2_q_corr(bpm2_q_corr),
    .corr_valid(corr_valid), .win_done(win_done),
    .sat_status(sat_status), .overrun(overrun)
  );

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void chan_model(input int raw, input int lut, input bit en,
                                     output int o, output bit s);
    int c;
    int d;
    c = int'($floor((lut + 64) / 128.0));
    d = raw - c;
    s = 1'b0;
    if (!en) o = raw;
    else if (d > 4095) begin o = 4095; s = 1'b1; end
    else if (d < -4096) begin o = -4096; s = 1'b1; end
    else o = d;
  endfunction

  // Reference model: per-cycle input history, windows tracked as cycle ranges.
  localparam int HN = 4096;
  bit hist_trig[HN];
  int hist_wl[HN];
  bit hist_en[HN];
  int hist_raw[HN][4];
  int hist_lut[HN][4];
  int cyc = 0;
  int rst_mark = 0;
  int m_first = -10, m_last = -20, m_done = -10, m_busy_end = -1;
  bit exp_valid = 0, exp_done = 0, exp_ov = 0;
  bit [3:0] exp_sat = 0, acc = 0;
  int exp_out[4] = '{0, 0, 0, 0};

  task automatic model_step();
    int k;
    int j;
    int o;
    bit s;
    k = cyc;
    if (rst) begin
      rst_mark = k;
      m_first = -10; m_last = -20; m_done = -10; m_busy_end = -1;
      exp_valid = 0; exp_done = 0; exp_ov = 0; exp_sat = 0; acc = 0;
      for (int c = 0; c < 4; c++) exp_out[c] = 0;
      return;
    end
    j = k - 3;
    if (j >= 0 && j >= rst_mark && hist_trig[j]) begin
      if (k - 1 > m_busy_end) begin
        m_first = k;
        m_last = k + hist_wl[k-1] - 1;
        m_done = k + hist_wl[k-1];
        m_busy_end = m_done;
        acc = 0;
      end else begin
        exp_ov = 1;
      end
    end
    exp_valid = (k >= m_first) && (k <= m_last);
    if (exp_valid) begin
      for (int c = 0; c < 4; c++) begin
        chan_model(hist_raw[j][c], hist_lut[j][c], hist_en[k-1], o, s);
        exp_out[c] = o;
        if (s) acc[c] = 1'b1;
      end
    end
    exp_done = (k == m_done);
    if (k == m_done + 1) exp_sat = acc;
  endtask

  always @(posedge clk) begin
    if (cyc < HN - 1) begin
      hist_trig[cyc] = trig && !rst;
      hist_wl[cyc] = int'(win_len);
      hist_en[cyc] = corr_en;
      for (int c = 0; c < 4; c++) begin
        hist_raw[cyc][c] = raw_s[c];
        hist_lut[cyc][c] = lut_s[c];
      end
      cyc++;
      model_step();
      #1;
      chk("m_valid", int'(corr_valid), int'(exp_valid));
      chk("m_done", int'(win_done), int'(exp_done));
      chk("m_overrun", int'(overrun), int'(exp_ov));
      chk("m_sat", int'(sat_status), int'(exp_sat));
      chk("m_b1i", int'(bpm1_i_corr), exp_out[0]);
      chk("m_b1q", int'(bpm1_q_corr), exp_out[1]);
      chk("m_b2i", int'(bpm2_i_corr), exp_out[2]);
      chk("m_b2q", int'(bpm2_q_corr), exp_out[3]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_raw(input int v);
    for (int c = 0; c < 4; c++) raw_s[c] = v;
  endtask

  task automatic set_lut(input int v);
    for (int c = 0; c < 4; c++) lut_s[c] = v;
  endtask

  initial begin
    int lv[4];
    int nval;
    int ndone;
    lv = '{192, -64, -65, 63};
    set_raw(0);
    set_lut(0);
    repeat (3) tick();
    chk("rst_valid", int'(corr_valid), 0);
    chk("rst_corr", int'(bpm2_q_corr), 0);
    rst = 1'b0;
    repeat (3) tick();

    // Zero correction ramp, win_len=4
    win_len = 8'd4;
    for (int i = 0; i < 4; i++) begin
      trig = (i == 0);
      set_raw(10 + i);
      tick();
    end
    trig = 1'b0;
    chk("zero_s1", int'(bpm1_i_corr), 11);
    tick();
    tick();
    chk("zero_s3", int'(bpm2_q_corr), 13);
    chk("zero_valid_last", int'(corr_valid), 1);
    tick();
    chk("zero_done", int'(win_done), 1);
    chk("zero_valid_off", int'(corr_valid), 0);
    tick();
    chk("zero_sat", int'(sat_status), 0);
    repeat (3) tick();

    // Rounding on raw=100
    set_raw(100);
    for (int i = 0; i < 4; i++) begin
      trig = (i == 0);
      set_lut(lv[i]);
      tick();
      if (i == 2) chk("round_p192", int'(bpm1_i_corr), 98);
    end
    trig = 1'b0;
    chk("round_m64", int'(bpm1_q_corr), 100);
    tick();
    chk("round_m65", int'(bpm2_i_corr), 101);
    tick();
    chk("round_p63", int'(bpm2_q_corr), 100);
    set_lut(0);
    repeat (4) tick();

    // Positive saturation on bpm1_q only
    win_len = 8'd1;
    set_raw(4000);
    lut_s[1] = -(200 << 7);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (2) tick();
    chk("sat_pos_b1q", int'(bpm1_q_corr), 4095);
    chk("sat_pos_b1i", int'(bpm1_i_corr), 4000);
    repeat (2) tick();
    chk("sat_pos_status", int'(sat_status), 4'b0010);
    repeat (2) tick();

    // Negative rail
    set_raw(-4096);
    set_lut(128);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (2) tick();
    chk("sat_neg_b2i", int'(bpm2_i_corr), -4096);
    repeat (2) tick();
    chk("sat_neg_status", int'(sat_status), 4'b1111);
    repeat (2) tick();

    // Bypass, including a value at the rail
    corr_en = 1'b0;
    win_len = 8'd2;
    set_raw(7);
    set_lut(50 << 7);
    trig = 1'b1;
    tick();
    trig = 1'b0;
    set_raw(4095);
    set_lut(-(200 << 7));
    tick();
    tick();
    chk("byp_7", int'(bpm1_i_corr), 7);
    tick();
    chk("byp_rail", int'(bpm2_q_corr), 4095);
    repeat (2) tick();
    chk("byp_sat", int'(sat_status), 0);
    corr_en = 1'b1;
    set_lut(0);
    set_raw(-3);
    repeat (2) tick();

    // Empty window
    win_len = 8'd0;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    repeat (2) tick();
    chk("wl0_done", int'(win_done), 1);
    chk("wl0_valid", int'(corr_valid), 0);
    repeat (3) tick();

    // Second trig two cycles into a 10-sample window
    win_len = 8'd10;
    trig = 1'b1;
    tick();
    trig = 1'b0;
    tick();
    trig = 1'b1;
    nval = 0;
    for (int i = 0; i < 20; i++) begin
      set_raw(i * 3 - 20);
      tick();
      trig = 1'b0;
      if (corr_valid) nval++;
    end
    chk("ovr_count", nval, 10);
    chk("ovr_flag", int'(overrun), 1);

    // Async reset at the third of eight samples
    win_len = 8'd8;
    for (int i = 0; i < 5; i++) begin
      trig = (i == 0);
      set_raw(500 + i);
      tick();
    end
    trig = 1'b0;
    chk("rstw_s3", int'(bpm1_i_corr), 502);
    rst = 1'b1;
    #1;
    chk("rstw_valid", int'(corr_valid), 0);
    chk("rstw_corr", int'(bpm1_i_corr), 0);
    chk("rstw_ovr", int'(overrun), 0);
    tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (win_done) ndone++;
    end
    chk("rstw_no_done", ndone, 0);

    trig = 1'b1;
    nval = 0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      set_raw(-100 - i);
      tick();
      trig = 1'b0;
      if (corr_valid) nval++;
      if (win_done) ndone++;
    end
    chk("post_rst_count", nval, 8);
    chk("post_rst_done", ndone, 1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
